// File: rtl/video_fb_pkg.sv
// Shared constants and types for the video frame buffer: the register map,
// the fill FSM states and the helper that gives the plane size.
package video_fb_pkg;

  localparam int FB_CTRL_BIT = 19;
  localparam int REG_CTRL    = 0;
  localparam int REG_FILL    = 1;

  localparam int HMAX_DEF = 640;
  localparam int VMAX_DEF = 480;
  localparam int PIX_MAX  = HMAX_DEF * VMAX_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  function automatic int pix_max(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/video_fb_if.sv
// Frame-buffer write bus coming from the video controller.
interface video_fb_if;
  logic        frame_cs;
  logic        frame_wr;
  logic [19:0] frame_addr;
  logic [31:0] frame_wr_data;

  modport master (output frame_cs, frame_wr, frame_addr, frame_wr_data);
  modport slave  (input  frame_cs, frame_wr, frame_addr, frame_wr_data);
endinterface

// File: rtl/fb_dual_port_ram.sv
// Inferred simple dual-port RAM: write port A, synchronous read-first port B.
module fb_dual_port_ram #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Non-blocking read alongside the write gives old data on an address collision.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
    b_data <= mem[b_addr];
  end

endmodule

// File: rtl/video_frame_buffer_core.sv
// Pixel plane overlaid on the video stream with key-colour transparency,
// written by the processor or cleared to one colour by a hardware fill engine.
module video_frame_buffer_core
  import video_fb_pkg::*;
#(
  parameter int CD        = 9,
  parameter int HMAX      = HMAX_DEF,
  parameter int VMAX      = VMAX_DEF,
  parameter int KEY_COLOR = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  video_fb_if.slave     fb,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb,
  output logic          fill_busy
);

  localparam int          PIX_N    = pix_max(HMAX, VMAX);
  localparam int          RAM_AW   = $clog2(PIX_N);
  localparam logic [18:0] PIX_LAST = 19'(PIX_N - 1);

  fill_state_t   state_q, state_d;
  logic [18:0]   fill_cnt;
  logic [CD-1:0] fill_color;
  logic          bypass;

  logic          wr_en, is_reg, ctrl_wr, fill_cmd, pix_wr;
  logic          a_we;
  logic [RAM_AW-1:0] a_addr;
  logic [CD-1:0] a_data;

  logic [18:0]   rd_addr;
  logic          in_range, in_d1;
  logic [CD-1:0] si_d1, rd_pixel;
  logic          unused_bits;

  assign wr_en    = fb.frame_cs & fb.frame_wr;
  assign is_reg   = fb.frame_addr[FB_CTRL_BIT];
  assign ctrl_wr  = wr_en & is_reg & (fb.frame_addr[0] == 1'(REG_CTRL));
  assign fill_cmd = wr_en & is_reg & (fb.frame_addr[0] == 1'(REG_FILL));
  assign pix_wr   = wr_en & ~is_reg & ({1'b0, fb.frame_addr[18:0]} < 20'(PIX_N));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fill_cmd) state_d = FILL;
      FILL: if (fill_cnt == PIX_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_busy = (state_q == FILL);
  end

  // A fill command arriving while a fill is running is ignored entirely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt   <= '0;
      fill_color <= '0;
    end else if (state_q == IDLE) begin
      if (fill_cmd) begin
        fill_cnt   <= '0;
        fill_color <= fb.frame_wr_data[CD-1:0];
      end
    end else begin
      fill_cnt <= (fill_cnt == PIX_LAST) ? '0 : fill_cnt + 19'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     bypass <= 1'b1;
    else if (ctrl_wr) bypass <= fb.frame_wr_data[0];
  end

  assign a_we   = fill_busy | pix_wr;
  assign a_addr = fill_busy ? fill_cnt[RAM_AW-1:0] : fb.frame_addr[RAM_AW-1:0];
  assign a_data = fill_busy ? fill_color : fb.frame_wr_data[CD-1:0];

  // The 640-wide plane maps y*640 onto two shifts; other widths use a constant multiply.
  always_comb begin
    if (HMAX == 640) rd_addr = (19'(y) << 9) + (19'(y) << 7) + 19'(x);
    else             rd_addr = 19'(y) * 19'(HMAX) + 19'(x);
    in_range = (x < 11'(HMAX)) && (y < 11'(VMAX));
  end

  fb_dual_port_ram #(
    .ADDR_W (RAM_AW),
    .DATA_W (CD)
  ) u_ram (
    .clk    (clk),
    .a_we   (a_we),
    .a_addr (a_addr),
    .a_data (a_data),
    .b_addr (rd_addr[RAM_AW-1:0]),
    .b_data (rd_pixel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_d1 <= 1'b0;
      si_d1 <= '0;
    end else begin
      in_d1 <= in_range;
      si_d1 <= si_rgb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) so_rgb <= '0;
    else if (bypass || !in_d1 || rd_pixel == CD'(KEY_COLOR)) so_rgb <= si_d1;
    else so_rgb <= rd_pixel;
  end

  assign unused_bits = ^{fb.frame_wr_data, rd_addr};

endmodule

// File: tb/tb_video_frame_buffer_core.sv
// Randomised bench for video_frame_buffer_core on a reduced 40x30 plane,
// checked every cycle against a behavioural model of the plane and overlay.
module tb_video_frame_buffer_core;
  import video_fb_pkg::*;

  localparam int CD   = 9;
  localparam int HMAX = 40;
  localparam int VMAX = 30;
  localparam int KEY  = 0;
  localparam int NPIX = HMAX * VMAX;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [10:0]   x, y;
  logic [CD-1:0] si_rgb, so_rgb;
  logic          fill_busy;

  video_fb_if fb();

  video_frame_buffer_core #(
    .CD (CD), .HMAX (HMAX), .VMAX (VMAX), .KEY_COLOR (KEY)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fb        (fb),
    .x         (x),
    .y         (y),
    .si_rgb    (si_rgb),
    .so_rgb    (so_rgb),
    .fill_busy (fill_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check_output(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Behavioural model: plane contents, overlay rule and fill progress.
  logic [CD-1:0] m_mem   [NPIX];
  bit            m_known [NPIX];
  bit            m_bypass, m_fill;
  int            m_idx;
  logic [CD-1:0] m_color;
  bit            h_in, h_known;
  logic [CD-1:0] h_si, h_pix;
  logic [CD-1:0] exp_so;
  bit            exp_valid, exp_busy;

  always @(posedge clk or negedge reset_n) begin : model
    bit            was_fill, cur_in, cur_known;
    int            idx;
    logic [CD-1:0] cur_pix;
    if (!reset_n) begin
      m_bypass = 1'b1; m_fill = 1'b0; m_idx = 0;
      h_in = 1'b0; h_known = 1'b1; h_si = '0; h_pix = '0;
      exp_so = '0; exp_valid = 1'b1; exp_busy = 1'b0;
    end else begin
      was_fill  = m_fill;
      exp_valid = m_bypass || !h_in || h_known;
      exp_so    = (m_bypass || !h_in || h_pix == CD'(KEY)) ? h_si : h_pix;
      cur_in    = (int'(x) < HMAX) && (int'(y) < VMAX);
      cur_pix   = '0;
      cur_known = 1'b1;
      if (cur_in) begin
        idx       = int'(y) * HMAX + int'(x);
        cur_pix   = m_mem[idx];
        cur_known = m_known[idx];
      end
      h_in = cur_in; h_known = cur_known; h_pix = cur_pix; h_si = si_rgb;
      if (m_fill) begin
        m_mem[m_idx] = m_color;
        m_known[m_idx] = 1'b1;
        m_idx++;
        if (m_idx == NPIX) m_fill = 1'b0;
      end
      if (fb.frame_cs && fb.frame_wr) begin
        if (fb.frame_addr[19]) begin
          if (!fb.frame_addr[0]) m_bypass = fb.frame_wr_data[0];
          else if (!was_fill) begin
            m_fill = 1'b1; m_idx = 0; m_color = fb.frame_wr_data[CD-1:0];
          end
        end else if (!was_fill && int'(fb.frame_addr[18:0]) < NPIX) begin
          m_mem[int'(fb.frame_addr[18:0])] = fb.frame_wr_data[CD-1:0];
          m_known[int'(fb.frame_addr[18:0])] = 1'b1;
        end
      end
      exp_busy = m_fill;
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      if (exp_valid) check_output("so_rgb", int'(so_rgb), int'(exp_so));
      check_output("fill_busy", int'(fill_busy), int'(exp_busy));
    end
  end

  task automatic apply_stimulus(input bit cs, input bit wr, input logic [19:0] addr,
                                input logic [31:0] data, input int px, input int py, input int psi);
    @(posedge clk);
    #2;
    fb.frame_cs = cs; fb.frame_wr = wr; fb.frame_addr = addr; fb.frame_wr_data = data;
    x = 11'(px); y = 11'(py); si_rgb = CD'(psi);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, '0, '0, HMAX, 0, 0);
  endtask

  task automatic write_pix(input int idx, input int val);
    apply_stimulus(1'b1, 1'b1, 20'(idx), 32'(val), HMAX, 0, 0);
  endtask

  task automatic write_ctrl(input int val);
    apply_stimulus(1'b1, 1'b1, 20'h80000, 32'(val), HMAX, 0, 0);
  endtask

  task automatic write_fill(input int color);
    apply_stimulus(1'b1, 1'b1, 20'h80001, 32'(color), HMAX, 0, 0);
  endtask

  task automatic random_read();
    apply_stimulus(1'b0, 1'b0, '0, '0, $urandom_range(0, HMAX + 2),
                   $urandom_range(0, VMAX + 2), $urandom_range(0, 511));
  endtask

  task automatic read_check(input string name, input int px, input int py,
                            input int psi, input int exp);
    apply_stimulus(1'b0, 1'b0, '0, '0, px, py, psi);
    idle();
    @(posedge clk);
    @(negedge clk);
    check_output(name, int'(so_rgb), exp);
  endtask

  // Runs a fill to completion; with inject set, pokes it with a pixel write,
  // a competing fill command and control writes part way through.
  task automatic run_fill(input int color, input bit inject, output int busy_cnt);
    write_fill(color);
    busy_cnt = 0;
    for (int c = 0; c < NPIX + 200; c++) begin
      if (inject && c == 100)      write_pix(10, 'h1FF);
      else if (inject && c == 200) write_fill('h155);
      else if (inject && c == 300) write_ctrl(1);
      else if (inject && c == 400) write_ctrl(0);
      else                         random_read();
      @(negedge clk);
      if (fill_busy) busy_cnt++;
      else break;
    end
  endtask

  initial begin
    int busy;
    fb.frame_cs = 1'b0; fb.frame_wr = 1'b0; fb.frame_addr = '0; fb.frame_wr_data = '0;
    x = 11'(HMAX); y = '0; si_rgb = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_so", int'(so_rgb), 0);
    check_output("rst_busy", int'(fill_busy), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    run_fill(0, 1'b0, busy);
    check_output("fill0_len", busy, 1200);

    write_ctrl(0);
    write_pix(5, 'h1AB);
    read_check("pix5", 5, 0, 'h055, 'h1AB);
    read_check("pix6_key", 6, 0, 'h0AA, 'h0AA);

    write_pix(41, 'h0F0);
    for (int i = 0; i < 3; i++)
      read_check("sweep", i, 1, 'h011 + i, (i == 1) ? 'h0F0 : 'h011 + i);
    write_pix(1199, 'h101);
    read_check("last_pix", 39, 29, 'h066, 'h101);

    write_ctrl(1);
    read_check("bypass", 5, 0, 'h077, 'h077);
    write_ctrl(0);
    read_check("oor_x", 40, 0, 'h123, 'h123);
    read_check("oor_y", 0, 30, 'h0C3, 'h0C3);

    run_fill('h03C, 1'b1, busy);
    check_output("fill_len", busy, 1200);
    read_check("fill_0", 0, 0, 'h0AA, 'h03C);
    read_check("fill_10", 10, 0, 'h0AA, 'h03C);
    read_check("fill_600", 0, 15, 'h0AA, 'h03C);
    read_check("fill_last", 39, 29, 'h0AA, 'h03C);

    write_pix(900, 'h0AA);
    write_fill('h0C6);
    busy = 0;
    for (int c = 0; c < NPIX; c++) begin
      random_read();
      @(negedge clk);
      if (fill_busy) busy++;
      if (busy == 600) break;
    end
    check_output("mid_reached", busy, 600);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid_rst_busy", int'(fill_busy), 0);
    check_output("mid_rst_so", int'(so_rgb), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    write_ctrl(0);
    read_check("mid_500", 20, 12, 'h011, 'h0C6);
    read_check("mid_900", 20, 22, 'h011, 'h0AA);

    write_pix(1200, 'h1EE);
    write_pix(2048, 'h1EE);
    read_check("no_wrap", 0, 0, 'h011, 'h0C6);

    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 100)
        apply_stimulus(1'b1, 1'b1, 20'($urandom_range(0, NPIX + 60)), 32'($urandom),
                       $urandom_range(0, HMAX + 2), $urandom_range(0, VMAX + 2), $urandom_range(0, 511));
      else if (r < 130)
        apply_stimulus(1'b1, 1'b1, 20'h80000, 32'($urandom_range(0, 1)),
                       $urandom_range(0, HMAX + 2), $urandom_range(0, VMAX + 2), $urandom_range(0, 511));
      else if (r < 132)
        apply_stimulus(1'b1, 1'b1, 20'h80001, 32'($urandom),
                       $urandom_range(0, HMAX + 2), $urandom_range(0, VMAX + 2), $urandom_range(0, 511));
      else
        random_read();
    end
    repeat (3) idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
